// File: rtl/dram_read_streamer.sv
// dram_read_streamer: fetches a DRAM word range in credit-limited bursts and
// streams it in order to the DRAM-to-CRAM swizzle stage.
module dram_read_streamer #(
  parameter int DWIDTH         = 40,
  parameter int DRAM_AWIDTH    = 32,
  parameter int CRAM_AWIDTH    = 14,
  parameter int LEN_WIDTH      = 16,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 32,
  parameter int LOG_FIFO_DEPTH = 5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DRAM_AWIDTH-1:0]    cmd_dram_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_num_words,
  input  logic [CRAM_AWIDTH-1:0]    cmd_cram_addr,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [DRAM_AWIDTH-1:0]    rd_req_addr,
  output logic [LOG_FIFO_DEPTH:0]   rd_req_len,
  input  logic                      rd_resp_valid,
  input  logic [DWIDTH-1:0]         rd_resp_data,
  input  logic                      swz_ready,
  output logic                      data_valid,
  output logic [DWIDTH-1:0]         mem_ctrl_data_in,
  output logic                      mem_ctrl_data_last,
  output logic [CRAM_AWIDTH-1:0]    ram_start_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);
  localparam int CW = LOG_FIFO_DEPTH + 1;
  localparam int SW = LOG_FIFO_DEPTH + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0] BURST_W = LEN_WIDTH'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, WAIT_SWZ, STREAM, FLUSH, DONE} state_t;

  state_t                   state_q;
  logic [DRAM_AWIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]     req_rem_q, emit_rem_q;
  logic [CRAM_AWIDTH-1:0]   cram_q;
  logic [CW-1:0]            outst_q, count_q;
  logic [LOG_FIFO_DEPTH-1:0] wptr_q, rptr_q;
  logic [DWIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic                     resp_v_q;
  logic [DWIDTH-1:0]        resp_d_q, dout_q;
  logic                     req_v_q, dv_q, last_q, done_q, ovf_q;
  logic [1:0]               guard_q;

  logic [CW-1:0] len_d, outst_d, count_d;
  logic [SW-1:0] credits_d;
  logic          full_d, push_d, pop_d, fire_d, issue_d;

  assign len_d     = (req_rem_q >= BURST_W) ? CW'(BURST_LEN) : CW'(req_rem_q);
  assign credits_d = SW'(count_q) + SW'(outst_q) + SW'(len_d);
  assign full_d    = count_q == DEPTH_C;
  assign push_d    = resp_v_q && !full_d;
  assign pop_d     = state_q == STREAM && count_q != '0 && emit_rem_q != '0;
  assign fire_d    = req_v_q && rd_req_ready;
  assign issue_d   = state_q == STREAM && !req_v_q && req_rem_q != '0 && credits_d <= DEPTH_S;
  // Outstanding drops when a beat is pushed, not when it is captured, so the
  // beat sitting in the input register still holds a credit.
  assign outst_d   = outst_q + (fire_d ? len_d : '0) - ((resp_v_q && outst_q != '0) ? CW'(1) : '0);
  assign count_d   = count_q + CW'(push_d) - CW'(pop_d);

  assign cmd_ready          = state_q == IDLE;
  assign busy               = state_q != IDLE;
  assign rd_req_valid       = req_v_q;
  assign rd_req_addr        = addr_q;
  assign rd_req_len         = len_d;
  assign data_valid         = dv_q;
  assign mem_ctrl_data_in   = dout_q;
  assign mem_ctrl_data_last = last_q;
  assign ram_start_addr     = cram_q;
  assign done               = done_q;
  assign overflow           = ovf_q;

  always_ff @(posedge clk) begin
    if (push_d) mem_q[wptr_q] <= resp_d_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      req_rem_q  <= '0;
      emit_rem_q <= '0;
      cram_q     <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      resp_v_q   <= 1'b0;
      resp_d_q   <= '0;
      dout_q     <= '0;
      req_v_q    <= 1'b0;
      dv_q       <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      guard_q    <= '0;
    end else begin
      resp_v_q <= rd_resp_valid;
      resp_d_q <= rd_resp_data;
      outst_q  <= outst_d;
      count_q  <= count_d;
      if (resp_v_q && full_d) ovf_q <= 1'b1;
      if (push_d) wptr_q <= wptr_q + 1'b1;
      req_v_q <= issue_d || (req_v_q && !rd_req_ready);
      if (fire_d) begin
        addr_q    <= addr_q + DRAM_AWIDTH'(len_d);
        req_rem_q <= req_rem_q - LEN_WIDTH'(len_d);
      end
      dv_q   <= pop_d;
      last_q <= pop_d && emit_rem_q == LEN_WIDTH'(1);
      if (pop_d) begin
        dout_q     <= mem_q[rptr_q];
        rptr_q     <= rptr_q + 1'b1;
        emit_rem_q <= emit_rem_q - LEN_WIDTH'(1);
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q     <= cmd_dram_addr;
          req_rem_q  <= cmd_num_words;
          emit_rem_q <= cmd_num_words;
          cram_q     <= cmd_cram_addr;
          state_q    <= cmd_num_words == '0 ? DONE : WAIT_SWZ;
          done_q     <= cmd_num_words == '0;
        end
        WAIT_SWZ: if (swz_ready) state_q <= STREAM;
        STREAM: if (pop_d && emit_rem_q == LEN_WIDTH'(1)) begin
          state_q <= FLUSH;
          guard_q <= '0;
        end
        FLUSH: if (guard_q != 2'd2) guard_q <= guard_q + 2'd1;
          else if (swz_ready) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        DONE: begin
          state_q <= IDLE;
          cram_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_read_streamer.sv
// tb_dram_read_streamer: scoreboard bench with an in-order DRAM model of
// programmable latency; all stimulus advances through step().
module tb_dram_read_streamer;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_dram_addr = '0;
  logic [15:0] cmd_num_words = '0;
  logic [13:0] cmd_cram_addr = '0;
  logic        rd_req_valid, rd_req_ready = 1'b1;
  logic [31:0] rd_req_addr;
  logic [5:0]  rd_req_len;
  logic        rd_resp_valid = 1'b0;
  logic [39:0] rd_resp_data = '0;
  logic        swz_ready = 1'b1;
  logic        data_valid, mem_ctrl_data_last, busy, done, overflow;
  logic [39:0] mem_ctrl_data_in;
  logic [13:0] ram_start_addr;

  dram_read_streamer dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dram_addr(cmd_dram_addr), .cmd_num_words(cmd_num_words), .cmd_cram_addr(cmd_cram_addr),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .swz_ready(swz_ready), .data_valid(data_valid), .mem_ctrl_data_in(mem_ctrl_data_in),
    .mem_ctrl_data_last(mem_ctrl_data_last), .ram_start_addr(ram_start_addr), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [39:0] d; logic l; } exp_t;
  typedef struct { logic [31:0] a; logic [5:0] l; } req_t;
  typedef struct { logic [31:0] a; int due; } pend_t;

  exp_t  exp_q[$];
  req_t  exp_req[$];
  pend_t pend[$];

  int pass_cnt = 0, chk_cnt = 0, cyc = 0, lat = 0;
  int emitted = 0, emitted_total = 0, req_beats = 0;
  int first_cyc = -1, last_cyc = 0, done_cyc = 0;
  bit in_xfer = 0, last_seen = 0, done_seen = 0;
  logic [13:0] exp_cram = '0;

  function automatic logic [39:0] md(input logic [31:0] a);
    return {a[7:0] ^ 8'h96, a};
  endfunction

  task automatic step();
    req_t r;
    pend_t p;
    exp_t e;
    if (rd_req_valid && rd_req_ready) begin
      chk_cnt++;
      if (exp_req.size() == 0)
        $display("FAIL req_unexpected: got addr %h len %0d, none expected", rd_req_addr, rd_req_len);
      else begin
        r = exp_req.pop_front();
        if (rd_req_addr !== r.a || rd_req_len !== r.l)
          $display("FAIL req: got addr %h len %0d want addr %h len %0d", rd_req_addr, rd_req_len, r.a, r.l);
        else pass_cnt++;
      end
      for (int i = 0; i < int'(rd_req_len); i++) begin
        p.a = rd_req_addr + 32'(i);
        p.due = cyc + 1 + lat;
        pend.push_back(p);
      end
      req_beats += int'(rd_req_len);
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      rd_resp_valid = 1'b1;
      rd_resp_data = md(p.a);
    end else begin
      rd_resp_valid = 1'b0;
      rd_resp_data = '0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (resetn) begin
      chk_cnt++;
      if (data_valid) begin
        if (exp_q.size() == 0)
          $display("FAIL data_unexpected: got %h, none expected", mem_ctrl_data_in);
        else begin
          e = exp_q.pop_front();
          if (mem_ctrl_data_in !== e.d || mem_ctrl_data_last !== e.l)
            $display("FAIL data: got %h last %b want %h last %b", mem_ctrl_data_in, mem_ctrl_data_last, e.d, e.l);
          else pass_cnt++;
        end
        emitted++;
        emitted_total++;
        if (first_cyc < 0) first_cyc = cyc;
        if (mem_ctrl_data_last) begin last_seen = 1; last_cyc = cyc; end
      end else if (mem_ctrl_data_last !== 1'b0)
        $display("FAIL last_idle: got %b want 0", mem_ctrl_data_last);
      else pass_cnt++;
      chk_cnt++;
      if (ram_start_addr !== (in_xfer ? exp_cram : 14'h0) || busy !== in_xfer)
        $display("FAIL ram_busy: got ram %h busy %b want ram %h busy %b", ram_start_addr, busy, in_xfer ? exp_cram : 14'h0, in_xfer);
      else pass_cnt++;
      chk_cnt++;
      if (req_beats - emitted_total > 32 || overflow !== 1'b0)
        $display("FAIL credits: got in-flight %0d overflow %b want <=32 and 0", req_beats - emitted_total, overflow);
      else pass_cnt++;
      if (done) begin done_seen = 1; done_cyc = cyc; in_xfer = 0; end
    end
  endtask

  task automatic start_cmd(input logic [31:0] a, input int n, input logic [13:0] c);
    exp_t e;
    req_t r;
    int rem;
    chk_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    else pass_cnt++;
    cmd_valid = 1'b1; cmd_dram_addr = a; cmd_num_words = 16'(n); cmd_cram_addr = c;
    exp_cram = c; in_xfer = 1; emitted = 0; last_seen = 0; done_seen = 0; first_cyc = -1;
    for (int i = 0; i < n; i++) begin
      e.d = md(a + 32'(i));
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
    rem = n;
    r.a = a;
    while (rem > 0) begin
      r.l = 6'(rem > 16 ? 16 : rem);
      exp_req.push_back(r);
      r.a = r.a + 32'(r.l);
      rem -= int'(r.l);
    end
    step();
    cmd_valid = 1'b0;
    chk_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL cmd_ready_busy: got %b want 0", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done_seen && k < bound) begin step(); k++; end
    chk_cnt++;
    if (!done_seen) $display("FAIL done_timeout: got no done in %0d cycles want done", bound);
    else pass_cnt++;
  endtask

  task automatic end_checks(input int n);
    chk_cnt++;
    if (emitted !== n || exp_q.size() != 0 || exp_req.size() != 0)
      $display("FAIL xfer_end: got %0d words (%0d/%0d left) want %0d (0/0)", emitted, exp_q.size(), exp_req.size(), n);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (done !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL done_pulse: got done %b cmd_ready %b want 0 1", done, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    step();
    step();
    chk_cnt++;
    if ({cmd_ready, busy, done, data_valid, rd_req_valid, overflow, mem_ctrl_data_last} !== 7'b1000000 ||
        ram_start_addr !== 14'h0 || mem_ctrl_data_in !== 40'h0 || rd_req_addr !== 32'h0 || rd_req_len !== 6'h0)
      $display("FAIL reset: got ctl %b ram %h data %h addr %h len %0d want 1000000 0 0 0 0",
               {cmd_ready, busy, done, data_valid, rd_req_valid, overflow, mem_ctrl_data_last},
               ram_start_addr, mem_ctrl_data_in, rd_req_addr, rd_req_len);
    else pass_cnt++;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    lat = 3;
    start_cmd(32'h100, 5, 14'h20);
    cmd_valid = 1'b1; cmd_cram_addr = 14'h3fff; cmd_num_words = 16'd9;
    repeat (3) step();
    cmd_valid = 1'b0;
    wait_done(200);
    chk_cnt++;
    if (last_cyc - first_cyc != 4 || done_cyc - last_cyc < 3)
      $display("FAIL single_timing: got span %0d done gap %0d want 4 and >=3", last_cyc - first_cyc, done_cyc - last_cyc);
    else pass_cnt++;
    end_checks(5);
  endtask

  task automatic test_zero_words();
    start_cmd(32'h700, 0, 14'h11);
    wait_done(10);
    end_checks(0);
  endtask

  task automatic test_multi_burst();
    lat = 0;
    start_cmd(32'h100, 80, 14'h0a5);
    wait_done(1000);
    end_checks(80);
  endtask

  task automatic test_credit_limit();
    lat = 50;
    start_cmd(32'h1000, 100, 14'h1234);
    wait_done(3000);
    end_checks(100);
  endtask

  task automatic test_swz_gating();
    int k = 0;
    lat = 2;
    swz_ready = 1'b0;
    start_cmd(32'h200, 24, 14'h155);
    repeat (20) begin
      step();
      chk_cnt++;
      if (rd_req_valid !== 1'b0) $display("FAIL swz_hold_req: got %b want 0", rd_req_valid);
      else pass_cnt++;
    end
    swz_ready = 1'b1;
    step();
    chk_cnt++;
    if (rd_req_valid !== 1'b0) $display("FAIL swz_rise_req: got %b want 0", rd_req_valid);
    else pass_cnt++;
    while (!last_seen && k < 500) begin step(); k++; end
    swz_ready = 1'b0;
    repeat (40) begin
      step();
      chk_cnt++;
      if (done !== 1'b0) $display("FAIL flush_hold_done: got %b want 0", done);
      else pass_cnt++;
    end
    swz_ready = 1'b1;
    wait_done(3);
    end_checks(24);
  endtask

  task automatic test_req_stall();
    int k = 0;
    lat = 1;
    rd_req_ready = 1'b0;
    start_cmd(32'h300, 20, 14'h2aa);
    while (!rd_req_valid && k < 20) begin step(); k++; end
    repeat (7) begin
      chk_cnt++;
      if (rd_req_valid !== 1'b1 || rd_req_addr !== 32'h300 || rd_req_len !== 6'd16)
        $display("FAIL stall_hold: got v %b addr %h len %0d want 1 300 16", rd_req_valid, rd_req_addr, rd_req_len);
      else pass_cnt++;
      step();
    end
    rd_req_ready = 1'b1;
    wait_done(500);
    end_checks(20);
  endtask

  task automatic test_abort();
    int k = 0;
    lat = 0;
    start_cmd(32'h400, 80, 14'h0f0);
    while (emitted < 30 && k < 400) begin step(); k++; end
    resetn = 1'b0;
    #1;
    chk_cnt++;
    if ({cmd_ready, busy, done, data_valid, rd_req_valid, overflow, mem_ctrl_data_last} !== 7'b1000000 ||
        ram_start_addr !== 14'h0 || emitted !== 30)
      $display("FAIL abort: got ctl %b ram %h emitted %0d want 1000000 0 30",
               {cmd_ready, busy, done, data_valid, rd_req_valid, overflow, mem_ctrl_data_last}, ram_start_addr, emitted);
    else pass_cnt++;
    exp_q.delete(); exp_req.delete(); pend.delete();
    in_xfer = 0; req_beats = 0; emitted_total = 0;
    rd_resp_valid = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    start_cmd(32'h500, 10, 14'h03a);
    wait_done(300);
    end_checks(10);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_zero_words();
    test_multi_burst();
    test_credit_limit();
    test_swz_gating();
    test_req_stall();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/dram_read_streamer.md
Name: dram_read_streamer

Overview:
- Upstream feeder for the DRAM-to-CRAM swizzle stage.
- Accepts one transfer command: DRAM base address, word count and CRAM start address.
- Issues burst read requests to the memory controller and buffers the returned beats in a credit-managed FIFO.
- Streams the words to the swizzle as data_valid / mem_ctrl_data_in / mem_ctrl_data_last. It holds ram_start_addr stable and never starts a new transfer until the swizzle reports ready (flushed).

Parameters:
DWIDTH, 40, data width; equals the swizzle MEM_CTRL_DWIDTH.
DRAM_AWIDTH, 32, DRAM word address width.
CRAM_AWIDTH, 14, CRAM address width (RAM_PORT_AWIDTH+LOG_NUM_CRAMS).
LEN_WIDTH, 16, width of the word count.
BURST_LEN, 16, maximum beats per read request; power of two.
FIFO_DEPTH, 32, receive FIFO entries; must be >= BURST_LEN.
LOG_FIFO_DEPTH, 5, log2(FIFO_DEPTH).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_dram_addr  in  DRAM_AWIDTH  first DRAM word address
cmd_num_words  in  LEN_WIDTH  words to transfer, >=1
cmd_cram_addr  in  CRAM_AWIDTH  CRAM start address for the swizzle
rd_req_valid  out  1  burst request valid
rd_req_ready  in  1  memory controller accepts request
rd_req_addr  out  DRAM_AWIDTH  burst start address
rd_req_len  out  LOG_FIFO_DEPTH+1  beats in burst, 1..BURST_LEN
rd_resp_valid  in  1  read beat valid; cannot be back-pressured; returned in order
rd_resp_data  in  DWIDTH  read beat
swz_ready  in  1  swizzle ready (flushed)
data_valid  out  1  word valid to swizzle
mem_ctrl_data_in  out  DWIDTH  word to swizzle
mem_ctrl_data_last  out  1  final word of transfer, qualified by data_valid
ram_start_addr  out  CRAM_AWIDTH  CRAM start address
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at completion
overflow  out  1  sticky: beat arrived while FIFO full

Behaviour:
- Reset (async assert, sync release) clears all state. All outputs are 0 except cmd_ready=1. FIFO is emptied; overflow is cleared.
- States and transitions:
  - IDLE: on cmd_valid&cmd_ready, latch the address, word count and CRAM address; set req_remaining = emit_remaining = cmd_num_words; go to WAIT_SWZ. cmd_num_words=0 is illegal: go straight to DONE with no requests issued.
  - WAIT_SWZ: go to STREAM in the cycle after swz_ready is sampled high.
  - STREAM: request issue and output drain run concurrently. Go to FLUSH when the last word is emitted.
  - FLUSH: wait 2 guard cycles, then wait for swz_ready=1, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- ram_start_addr drives the latched value from command accept until return to IDLE. It is 0 in IDLE.
- Request issue:
  - rd_req_len = min(BURST_LEN, req_remaining).
  - rd_req_valid is asserted only if req_remaining>0 and credits_used + rd_req_len <= FIFO_DEPTH. credits_used = FIFO occupancy + beats outstanding.
  - Once asserted, rd_req_valid and its addr/len stay stable until rd_req_ready.
  - On handshake: address advances by len, req_remaining decreases by len, outstanding increases by len.
- Each rd_resp_valid pushes one beat and decrements outstanding. If the FIFO is full, the beat is dropped and overflow is set (sticky).
- Output path:
  - Registered. Every cycle the FIFO is non-empty in STREAM, pop one word. data_valid=1 and mem_ctrl_data_in=word appear the following cycle.
  - Latency: a beat sampled at edge N, with the FIFO empty, appears on the outputs after edge N+2.
  - Gaps in data_valid are permitted; the swizzle has no backpressure.
- mem_ctrl_data_last=1 together with data_valid on the word where emit_remaining reaches 0. It is 0 at all other times.
- Simultaneous push and pop on the same cycle keeps occupancy unchanged. Credits are freed on pop.
- cmd_valid is ignored outside IDLE.
- Reset mid-transfer aborts immediately. Beats still in flight after reset are not this block's concern.

Test Plan:
- Single short transfer: cmd_num_words=5, addr 0x100, cram 0x20. Expect 1 request (0x100, len 5). After responses, 5 contiguous data_valid with last on the 5th. ram_start_addr=0x20 throughout. done 3+ cycles after last, once swz_ready=1.
- Multi-burst, 80 words, rd_req_ready always 1, zero-latency responses. Expect 5 requests at 0x100, 0x110, …, 0x140, each len 16. Exactly 80 data_valid cycles, last only on the 80th. Data order is preserved.
- Credit limit, 100 words, responses delayed 50 cycles. Outstanding + occupancy never exceeds 32. Final request has len 4. overflow stays 0.
- swz_ready held low for 20 cycles after command. No rd_req_valid until the cycle after swz_ready rises. In FLUSH with swz_ready low for 40 cycles, done is withheld until it rises.
- rd_req_ready stalls for 7 cycles. rd_req_valid, addr and len are held stable for the whole stall.
- Async reset asserted mid-STREAM, 30 of 80 words emitted. All outputs clear immediately and cmd_ready=1. A new 10-word command then completes normally.
